// File: rtl/combo_pkg.sv
// rtl/combo_pkg.sv - shared widths and FSM state encoding for the combo sweep controller
package combo_pkg;

  localparam int VEC_W = 5;
  localparam int RES_W = 32;
  localparam int CNT_W = 6;
  localparam int SET_W = 4;

  localparam logic [VEC_W-1:0] VEC_LAST = 5'd31;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FIN    = 2'd3;

endpackage

// File: rtl/combo_dp.sv
// rtl/combo_dp.sv - combinational datapath z = (a & b) | (c & d & ~e)
module combo_dp (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  output logic z
);

  // Pure sum-of-products; the controller waits SETTLE cycles before sampling it.
  always_comb begin
    z = (a & b) | (c & d & ~e);
  end

endmodule

// File: rtl/combo_sweep_ctrl.sv
// rtl/combo_sweep_ctrl.sv - sweeps all 32 input vectors through combo_dp and captures the truth table
module combo_sweep_ctrl
  import combo_pkg::*;
#(
  parameter int          SETTLE = 1,
  parameter logic [31:0] GOLDEN = 32'hFF404040
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] vec,
  output logic             z_obs,
  output logic [RES_W-1:0] result,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             pass
);

  // Counter reload value: APPLY lasts SETTLE cycles, counting SETTLE-1 down to 0.
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);

  logic [1:0]       state;
  logic [SET_W-1:0] settle_cnt;
  logic             z;

  combo_dp u_dp (
    .a (vec[4]),
    .b (vec[3]),
    .c (vec[2]),
    .d (vec[1]),
    .e (vec[0]),
    .z (z)
  );

  // Status outputs follow the state register directly.
  always_comb begin
    busy  = (state != ST_IDLE);
    z_obs = z;
  end

  // Sweep FSM: abort while busy overrides every state; done is registered on leaving FIN
  // so it shows for exactly one cycle alongside the freshly updated pass flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec        <= '0;
      result     <= '0;
      ones_cnt   <= '0;
      pass       <= 1'b0;
      done       <= 1'b0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      if ((state != ST_IDLE) && abort) begin
        state <= ST_IDLE;
        pass  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              result     <= '0;
              ones_cnt   <= '0;
              pass       <= 1'b0;
              vec        <= '0;
              settle_cnt <= SETTLE_LOAD;
              state      <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            if (settle_cnt == '0) begin
              state <= ST_SAMPLE;
            end else begin
              settle_cnt <= settle_cnt - 4'd1;
            end
          end
          ST_SAMPLE: begin
            result[vec] <= z;
            ones_cnt    <= ones_cnt + {{(CNT_W-1){1'b0}}, z};
            if (vec == VEC_LAST) begin
              state <= ST_FIN;
            end else begin
              vec        <= vec + 5'd1;
              settle_cnt <= SETTLE_LOAD;
              state      <= ST_APPLY;
            end
          end
          ST_FIN: begin
            done  <= 1'b1;
            pass  <= (result == GOLDEN);
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
